// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry return buffer and
// abandoned-request tracking so a redirect never breaks the memory handshake.
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    PC_STEP     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_detected,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pc_ID,
    output logic [ADDR_WIDTH-1:0]  pc_plus_ID,
    output logic [INSTR_WIDTH-1:0] instr_ID,
    output logic                   valid_ID
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    logic [1:0]             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0]  drop_addr_reg, drop_addr_next;
    logic [ADDR_WIDTH-1:0]  buf_pc_reg, buf_pc_next;
    logic [INSTR_WIDTH-1:0] buf_instr_reg, buf_instr_next;
    logic [ADDR_WIDTH-1:0]  pc_id_reg, pc_id_next;
    logic [INSTR_WIDTH-1:0] instr_id_reg, instr_id_next;
    logic                   valid_id_reg, valid_id_next;
    logic [ADDR_WIDTH-1:0]  pc_inc;

    assign pc_inc = pc_reg + STEP;

    // The request is forced low while reset is asserted, independent of state.
    assign imem_req   = rst && (state_reg != ST_HOLD);
    assign imem_addr  = (state_reg == ST_DROP) ? drop_addr_reg : pc_reg;
    assign pc_ID      = pc_id_reg;
    assign pc_plus_ID = pc_id_reg + STEP;
    assign instr_ID   = instr_id_reg;
    assign valid_ID   = valid_id_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        buf_pc_next    = buf_pc_reg;
        buf_instr_next = buf_instr_reg;
        pc_id_next     = pc_id_reg;
        instr_id_next  = instr_id_reg;
        valid_id_next  = valid_id_reg;

        case (state_reg)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_next       = branch_target;
                    valid_id_next = 1'b0;
                    // An unaccepted request must still complete at its old address.
                    if (!imem_ready) begin
                        drop_addr_next = pc_reg;
                        state_next     = ST_DROP;
                    end
                end else if (hazard_detected) begin
                    if (imem_ready) begin
                        buf_pc_next    = pc_reg;
                        buf_instr_next = imem_rdata;
                        pc_next        = pc_inc;
                        state_next     = ST_HOLD;
                    end
                end else if (imem_ready) begin
                    pc_id_next    = pc_reg;
                    instr_id_next = imem_rdata;
                    valid_id_next = 1'b1;
                    pc_next       = pc_inc;
                end else begin
                    valid_id_next = 1'b0;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    buf_pc_next    = '0;
                    buf_instr_next = '0;
                    pc_next        = branch_target;
                    valid_id_next  = 1'b0;
                    state_next     = ST_RUN;
                end else if (!hazard_detected) begin
                    pc_id_next    = buf_pc_reg;
                    instr_id_next = buf_instr_reg;
                    valid_id_next = 1'b1;
                    state_next    = ST_RUN;
                end
            end

            ST_DROP: begin
                if (branch_taken) begin
                    pc_next       = branch_target;
                    valid_id_next = 1'b0;
                end else if (!hazard_detected) begin
                    valid_id_next = 1'b0;
                end
                // Completion of the abandoned request always ends the drop,
                // even when a further redirect arrives in the same cycle.
                if (imem_ready) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            pc_reg        <= RESET_PC;
            drop_addr_reg <= '0;
            buf_pc_reg    <= '0;
            buf_instr_reg <= '0;
            pc_id_reg     <= '0;
            instr_id_reg  <= '0;
            valid_id_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
            buf_pc_reg    <= buf_pc_next;
            buf_instr_reg <= buf_instr_next;
            pc_id_reg     <= pc_id_next;
            instr_id_reg  <= instr_id_next;
            valid_id_reg  <= valid_id_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: two instances (reset PC 0 and 0xFFFFFFFC)
// compared every cycle against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hazard, branch, ready;
    logic [31:0] target;

    logic        req0, req1, val0, val1;
    logic [31:0] addr0, addr1, rdata0, rdata1;
    logic [31:0] pcid0, pcid1, pcp0, pcp1, ins0, ins1;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    assign rdata0 = word_at(addr0);
    assign rdata1 = word_at(addr1);

    fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst), .hazard_detected(hazard), .branch_taken(branch),
        .branch_target(target), .imem_req(req0), .imem_addr(addr0),
        .imem_ready(ready), .imem_rdata(rdata0), .pc_ID(pcid0),
        .pc_plus_ID(pcp0), .instr_ID(ins0), .valid_ID(val0));

    fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .hazard_detected(hazard), .branch_taken(branch),
        .branch_target(target), .imem_req(req1), .imem_addr(addr1),
        .imem_ready(ready), .imem_rdata(rdata1), .pc_ID(pcid1),
        .pc_plus_ID(pcp1), .instr_ID(ins1), .valid_ID(val1));

    // Model view: next fetch address, optional parked word, optional
    // outstanding abandoned fetch, and what decode currently sees.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] drop_addr;
        logic [31:0] buf_pc;
        logic [31:0] buf_ins;
        logic [31:0] id_pc;
        logic [31:0] id_ins;
        logic        parked;
        logic        dropping;
        logic        id_valid;
    } model_t;

    model_t      m0, m1;

    function automatic model_t mreset(input logic [31:0] rpc);
        model_t s;
        s = '0;
        s.pc = rpc;
        return s;
    endfunction

    function automatic model_t mstep(input model_t s, input logic b, input logic [31:0] t,
                                     input logic h, input logic y);
        model_t n;
        n = s;
        if (s.dropping) begin
            if (b) begin n.pc = t; n.id_valid = 1'b0; end
            else if (!h) n.id_valid = 1'b0;
            if (y) n.dropping = 1'b0;
        end else if (s.parked) begin
            if (b) begin
                n.parked = 1'b0; n.pc = t; n.id_valid = 1'b0;
            end else if (!h) begin
                n.parked = 1'b0; n.id_pc = s.buf_pc; n.id_ins = s.buf_ins; n.id_valid = 1'b1;
            end
        end else if (b) begin
            n.pc = t; n.id_valid = 1'b0;
            if (!y) begin n.dropping = 1'b1; n.drop_addr = s.pc; end
        end else if (h) begin
            if (y) begin
                n.parked = 1'b1; n.buf_pc = s.pc; n.buf_ins = word_at(s.pc); n.pc = s.pc + 32'd4;
            end
        end else if (y) begin
            n.id_pc = s.pc; n.id_ins = word_at(s.pc); n.id_valid = 1'b1; n.pc = s.pc + 32'd4;
        end else begin
            n.id_valid = 1'b0;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string d, input model_t s, input logic r,
                             input logic q, input logic [31:0] a, input logic [31:0] p,
                             input logic [31:0] pp, input logic [31:0] i, input logic v);
        check({d, ".imem_req"},   32'(q), 32'(r && !s.parked));
        check({d, ".imem_addr"},  a, s.dropping ? s.drop_addr : s.pc);
        check({d, ".pc_ID"},      p, s.id_pc);
        check({d, ".pc_plus_ID"}, pp, s.id_pc + 32'd4);
        check({d, ".instr_ID"},   i, s.id_ins);
        check({d, ".valid_ID"},   32'(v), 32'(s.id_valid));
    endtask

    task automatic check_all();
        check_dut("dut0", m0, rst, req0, addr0, pcid0, pcp0, ins0, val0);
        check_dut("dut1", m1, rst, req1, addr1, pcid1, pcp1, ins1, val1);
    endtask

    task automatic cycle(input logic r, input logic b, input logic [31:0] t,
                         input logic h, input logic y);
        @(negedge clk);
        rst = r; branch = b; target = t; hazard = h; ready = y;
        if (!r) begin
            m0 = mreset(32'h0);
            m1 = mreset(32'hFFFF_FFFC);
        end
        #1;
        check_all();
        if (req0 && ready)
            $display("txn dut0 addr=%h word=%h br=%0d hz=%0d", addr0, rdata0, b, h);
        @(posedge clk);
        if (r) begin
            m0 = mstep(m0, b, t, h, y);
            m1 = mstep(m1, b, t, h, y);
        end
    endtask

    task automatic literal_reset_checks();
        check("rst.req0",  32'(req0), 32'd0);
        check("rst.addr0", addr0, 32'h0);
        check("rst.pcp0",  pcp0, 32'h4);
        check("rst.ins0",  ins0, 32'h0);
        check("rst.val0",  32'(val0), 32'd0);
        check("rst.req1",  32'(req1), 32'd0);
        check("rst.addr1", addr1, 32'hFFFF_FFFC);
        check("rst.pcid1", pcid1, 32'h0);
    endtask

    initial begin
        logic [31:0] tmp;
        logic        b, h, y;
        rst = 1'b0; branch = 1'b0; hazard = 1'b0; ready = 1'b0; target = '0;
        m0 = mreset(32'h0);
        m1 = mreset(32'hFFFF_FFFC);

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        #2 literal_reset_checks();

        // Zero-wait sequential fetch from reset.
        cycle(1, 0, 0, 0, 1);
        #2;
        check("seq.addr0", addr0, 32'h4);
        check("seq.pcid0", pcid0, 32'h0);
        check("seq.ins0",  ins0, word_at(32'h0));
        check("seq.val0",  32'(val0), 32'd1);
        check("wrap.addr1", addr1, 32'h0);
        check("wrap.pcid1", pcid1, 32'hFFFF_FFFC);
        check("wrap.pcp1",  pcp1, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1);

        // Three-cycle hazard while memory is ready: one word parked.
        cycle(1, 0, 0, 1, 1);
        #2;
        check("hz.req0",  32'(req0), 32'd0);
        check("hz.pcid0", pcid0, 32'h14);
        cycle(1, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 1);
        #2;
        check("hz.resume.pcid0", pcid0, 32'h18);
        check("hz.resume.addr0", addr0, 32'h1C);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);

        // Branch while ready.
        cycle(1, 1, 32'h100, 0, 1);
        #2;
        check("br.addr0", addr0, 32'h100);
        check("br.val0",  32'(val0), 32'd0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Branch during a wait: old address held until the request completes.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 32'h200, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        #2;
        check("drop.addr0", addr0, 32'h200);
        check("drop.val0",  32'(val0), 32'd0);
        cycle(1, 0, 0, 0, 1);

        // Branch and hazard together from HOLD.
        cycle(1, 0, 0, 1, 1);
        cycle(1, 1, 32'h300, 1, 1);
        #2;
        check("holdbr.addr0", addr0, 32'h300);
        check("holdbr.req0",  32'(req0), 32'd1);
        check("holdbr.val0",  32'(val0), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            tmp = $urandom;
            tmp[1:0] = 2'b00;
            b = ($urandom_range(0, 9) == 0);
            h = ($urandom_range(0, 3) == 0);
            y = ($urandom_range(0, 99) < 70);
            cycle(1, b, tmp, h, y);
        end

        // Asynchronous reset in the middle of an outstanding dropped request.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 32'h500, 0, 0);
        @(negedge clk);
        branch = 1'b0; hazard = 1'b0; ready = 1'b0;
        #1 check_all();
        #2 rst = 1'b0;
        #1 literal_reset_checks();
        m0 = mreset(32'h0);
        m1 = mreset(32'hFFFF_FFFC);
        @(posedge clk);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        for (int i = 0; i < 500; i++) begin
            tmp = $urandom;
            tmp[1:0] = 2'b00;
            b = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 2) == 0);
            y = ($urandom_range(0, 99) < 60);
            cycle(1, b, tmp, h, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
